// File: rtl/zuse_host_ctrl_if.sv
// Host-side bundle for the tinyZuse command controller: operand/opcode request,
// byte-level uart_tx/uart_rx handshakes and the result/status return path.
interface zuse_host_ctrl_if;
  logic        start;
  logic [2:0]  op;
  logic        a_s;
  logic [6:0]  a_e;
  logic [14:0] a_m;
  logic        b_s;
  logic [6:0]  b_e;
  logic [14:0] b_m;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_busy;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        res_s;
  logic [6:0]  res_e;
  logic [14:0] res_m;
  logic [2:0]  flags;
  logic        busy;
  logic        done;
  logic        error;

  modport master (
    input  start, op, a_s, a_e, a_m, b_s, b_e, b_m,
    input  tx_busy, rx_data, rx_valid,
    output tx_data, tx_en,
    output res_s, res_e, res_m, flags, busy, done, error
  );

  modport slave (
    output start, op, a_s, a_e, a_m, b_s, b_e, b_m,
    output tx_busy, rx_data, rx_valid,
    input  tx_data, tx_en,
    input  res_s, res_e, res_m, flags, busy, done, error
  );
endinterface

// File: rtl/zuse_host_ctrl.sv
// Host-side initiator for the tinyZuse UART protocol: loads R1/R2, launches the
// FPU op, then reads back the result word (READRS) and status byte (READSTAT).
module zuse_host_ctrl #(
  parameter int GAP_CYCLES     = 2000,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic             clk,
  input  logic             reset,
  zuse_host_ctrl_if.master bus
);

  localparam int CNT_MAX = (GAP_CYCLES > TIMEOUT_CYCLES) ? GAP_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);

  // idx_r points at the next byte to send; in RX_WAIT it tells which reply is expected
  localparam logic [3:0] IDX_OP_BYTE = 4'd8;
  localparam logic [3:0] IDX_READRS  = 4'd9;
  localparam logic [3:0] IDX_READST  = 4'd10;
  localparam logic [3:0] IDX_RX_STAT = 4'd11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    PULSE   = 3'd2,
    WAIT_HI = 3'd3,
    WAIT_LO = 3'd4,
    GAP     = 3'd5,
    RX_WAIT = 3'd6,
    FINISH  = 3'd7
  } state_t;

  state_t             state_r, state_n;
  logic [3:0]         idx_r, idx_n;
  logic [CNT_W-1:0]   cnt_r;
  logic [1:0]         rx_cnt_r;
  logic [2:0]         op_r;
  logic [22:0]        a_word_r, b_word_r;
  logic [7:0]         rx_b0_r, rx_b1_r;
  logic [7:0]         tx_data_r;
  logic               tx_en_r;
  logic               res_s_r;
  logic [6:0]         res_e_r;
  logic [14:0]        res_m_r;
  logic [2:0]         flags_r;
  logic               busy_r, done_r, error_r;

  logic latch_s, cnt_clr_s, cnt_inc_s, rx_take_s, res_load_s, flags_load_s, fail_s;

  // Words go out as {s,e}, m[14:7], {m[6:0],0}
  function automatic logic [7:0] tx_byte(input logic [3:0]  idx,
                                         input logic [2:0]  opc,
                                         input logic [22:0] wa,
                                         input logic [22:0] wb);
    logic [7:0] tx_v;
    case (idx)
      4'd0:    tx_v = 8'h82;
      4'd1:    tx_v = wa[22:15];
      4'd2:    tx_v = wa[14:7];
      4'd3:    tx_v = {wa[6:0], 1'b0};
      4'd4:    tx_v = 8'h83;
      4'd5:    tx_v = wb[22:15];
      4'd6:    tx_v = wb[14:7];
      4'd7:    tx_v = {wb[6:0], 1'b0};
      4'd8:    tx_v = 8'h88 + {5'b00000, opc};
      4'd9:    tx_v = 8'h87;
      4'd10:   tx_v = 8'h84;
      default: tx_v = 8'h00;
    endcase
    return tx_v;
  endfunction

  // Next-state and control strobes
  always_comb begin
    state_n      = state_r;
    idx_n        = idx_r;
    latch_s      = 1'b0;
    cnt_clr_s    = 1'b0;
    cnt_inc_s    = 1'b0;
    rx_take_s    = 1'b0;
    res_load_s   = 1'b0;
    flags_load_s = 1'b0;
    fail_s       = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          latch_s = 1'b1;
          idx_n   = 4'd0;
          if (bus.op > 3'd4) begin
            fail_s  = 1'b1;
            state_n = FINISH;
          end else begin
            state_n = LOAD;
          end
        end else begin
          state_n = IDLE;
        end
      end
      LOAD: begin
        if (!bus.tx_busy) begin
          state_n = PULSE;
        end else begin
          state_n = LOAD;
        end
      end
      PULSE: begin
        state_n = WAIT_HI;
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_n = WAIT_LO;
        end else begin
          state_n = WAIT_HI;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          idx_n     = idx_r + 4'd1;
          cnt_clr_s = 1'b1;
          case (idx_r)
            IDX_OP_BYTE: state_n = GAP;
            IDX_READRS:  state_n = RX_WAIT;
            IDX_READST:  state_n = RX_WAIT;
            default:     state_n = LOAD;
          endcase
        end else begin
          state_n = WAIT_LO;
        end
      end
      GAP: begin
        if (cnt_r == GAP_LAST) begin
          state_n = LOAD;
        end else begin
          cnt_inc_s = 1'b1;
          state_n   = GAP;
        end
      end
      RX_WAIT: begin
        // A byte arriving on the expiry cycle still counts
        if (bus.rx_valid) begin
          rx_take_s = 1'b1;
          cnt_clr_s = 1'b1;
          if (idx_r == IDX_RX_STAT) begin
            flags_load_s = 1'b1;
            state_n      = FINISH;
          end else if (rx_cnt_r == 2'd2) begin
            res_load_s = 1'b1;
            state_n    = LOAD;
          end else begin
            state_n = RX_WAIT;
          end
        end else if (cnt_r == TO_LAST) begin
          fail_s  = 1'b1;
          state_n = FINISH;
        end else begin
          cnt_inc_s = 1'b1;
          state_n   = RX_WAIT;
        end
      end
      FINISH: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State, byte index, shared gap/timeout counter and rx byte counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      idx_r    <= 4'd0;
      cnt_r    <= {CNT_W{1'b0}};
      rx_cnt_r <= 2'd0;
    end else begin
      state_r <= state_n;
      idx_r   <= idx_n;
      if (cnt_clr_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (cnt_inc_s) begin
        cnt_r <= cnt_r + 1'b1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (state_r != RX_WAIT) begin
        rx_cnt_r <= 2'd0;
      end else if (rx_take_s && (rx_cnt_r != 2'd2)) begin
        rx_cnt_r <= rx_cnt_r + 2'd1;
      end else begin
        rx_cnt_r <= rx_cnt_r;
      end
    end
  end

  // Operand latch, tx byte/strobe, reply capture and registered status outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r      <= 3'd0;
      a_word_r  <= 23'd0;
      b_word_r  <= 23'd0;
      rx_b0_r   <= 8'h00;
      rx_b1_r   <= 8'h00;
      tx_data_r <= 8'h00;
      tx_en_r   <= 1'b0;
      res_s_r   <= 1'b0;
      res_e_r   <= 7'd0;
      res_m_r   <= 15'd0;
      flags_r   <= 3'd0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      if (latch_s) begin
        op_r     <= bus.op;
        a_word_r <= {bus.a_s, bus.a_e, bus.a_m};
        b_word_r <= {bus.b_s, bus.b_e, bus.b_m};
      end
      if (state_n == LOAD) begin
        tx_data_r <= tx_byte(idx_n, op_r, a_word_r, b_word_r);
      end
      tx_en_r <= (state_n == PULSE);
      if (rx_take_s && (rx_cnt_r == 2'd0)) begin
        rx_b0_r <= bus.rx_data;
      end
      if (rx_take_s && (rx_cnt_r == 2'd1)) begin
        rx_b1_r <= bus.rx_data;
      end
      // Result only changes once the third byte is in hand; its LSB is padding
      if (res_load_s) begin
        res_s_r <= rx_b0_r[7];
        res_e_r <= rx_b0_r[6:0];
        res_m_r <= {rx_b1_r, bus.rx_data[7:1]};
      end
      if (flags_load_s) begin
        flags_r <= bus.rx_data[2:0];
      end
      busy_r <= (state_n != IDLE) && (state_n != FINISH);
      done_r <= (state_n == FINISH);
      if (fail_s) begin
        error_r <= 1'b1;
      end else if (latch_s) begin
        error_r <= 1'b0;
      end else begin
        error_r <= error_r;
      end
    end
  end

  assign bus.tx_data = tx_data_r;
  assign bus.tx_en   = tx_en_r;
  assign bus.res_s   = res_s_r;
  assign bus.res_e   = res_e_r;
  assign bus.res_m   = res_m_r;
  assign bus.flags   = flags_r;
  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.error   = error_r;

endmodule
